// File: rtl/flash_op_sequencer.sv
// Host flash operation sequencer: turns read/program/erase/status requests into
// flash_ctrl instruction words and data-FIFO bytes, then waits on R/B#.
module flash_op_sequencer #(
  parameter int unsigned ADDR_COL_CYC = 2,
  parameter int unsigned ADDR_ROW_CYC = 3,
  parameter int unsigned TWB_CYC      = 8,
  parameter logic [23:0] TIMEOUT_CYC  = 24'd4000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [1:0]  op_code,
  input  logic [15:0] op_col,
  input  logic [23:0] op_row,
  input  logic [12:0] op_len,
  input  logic        wdat_valid,
  input  logic [7:0]  wdat,
  output logic        wdat_ready,
  output logic        instr_wr,
  output logic [31:0] instr_word,
  input  logic        instr_full,
  input  logic        instr_empty,
  output logic        dq_wr,
  output logic [7:0]  dq_byte,
  input  logic        dq_full,
  input  logic        flash_rdy,
  output logic        busy,
  output logic        op_done,
  output logic [1:0]  op_status
);

  localparam int unsigned CNT_W        = 13;
  localparam int unsigned ADDR_ALL_CYC = ADDR_COL_CYC + ADDR_ROW_CYC;
  localparam logic [12:0] MAX_LEN      = 13'd4096;

  localparam logic [7:0] MODE_CMD      = 8'd2;
  localparam logic [7:0] MODE_ADDR     = 8'd3;
  localparam logic [7:0] MODE_DIN      = 8'd4;
  localparam logic [7:0] MODE_DOUT     = 8'd5;
  localparam logic [7:0] MODE_DOUT_END = 8'd6;

  localparam logic [1:0] OP_READ   = 2'd0;
  localparam logic [1:0] OP_PROG   = 2'd1;
  localparam logic [1:0] OP_ERASE  = 2'd2;
  localparam logic [1:0] OP_STATUS = 2'd3;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CMD1,
    S_ADDR,
    S_PAYLOAD,
    S_CMD2,
    S_DRAIN,
    S_TWB,
    S_WAIT_RB,
    S_RDATA,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic               hdr_q, hdr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [23:0]        tcnt_q, tcnt_d;
  logic [1:0]         status_q, status_d;
  logic [1:0]         code_q;
  logic [15:0]        col_q;
  logic [23:0]        row_q;
  logic [12:0]        len_q;

  logic [7:0]         cmd1_byte;
  logic [7:0]         cmd2_byte;
  logic [7:0]         addr_byte;
  logic [CNT_W-1:0]   addr_last;
  logic [CNT_W-1:0]   row_idx;
  logic               len_bad;

  function automatic logic [31:0] instr_fn(input logic [7:0] mode, input logic [11:0] rpt);
    return {12'h000, rpt, mode};
  endfunction

  // Opcode-dependent command bytes and address byte selection
  always_comb begin
    cmd1_byte = 8'h00;
    cmd2_byte = 8'h30;
    case (code_q)
      OP_PROG:   begin cmd1_byte = 8'h80; cmd2_byte = 8'h10; end
      OP_ERASE:  begin cmd1_byte = 8'h60; cmd2_byte = 8'hd0; end
      OP_STATUS: begin cmd1_byte = 8'h70; cmd2_byte = 8'h00; end
      default:   begin cmd1_byte = 8'h00; cmd2_byte = 8'h30; end
    endcase
    addr_last = (code_q == OP_ERASE) ? CNT_W'(ADDR_ROW_CYC - 1) : CNT_W'(ADDR_ALL_CYC - 1);
    row_idx   = (code_q == OP_ERASE) ? cnt_q : cnt_q - CNT_W'(ADDR_COL_CYC);
    if (code_q != OP_ERASE && cnt_q < CNT_W'(ADDR_COL_CYC)) begin
      addr_byte = 8'(col_q >> {cnt_q, 3'b000});
    end else begin
      addr_byte = 8'(row_q >> {row_idx, 3'b000});
    end
    len_bad = (op_code == OP_READ || op_code == OP_PROG) &&
              (op_len == 13'd0 || op_len > MAX_LEN);
  end

  // State and operation latches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      hdr_q    <= 1'b0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
      status_q <= 2'b00;
      code_q   <= 2'd0;
      col_q    <= '0;
      row_q    <= '0;
      len_q    <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
      status_q <= status_d;
      if (state_q == S_IDLE && op_valid) begin
        code_q <= op_code;
        col_q  <= op_col;
        row_q  <= op_row;
        len_q  <= (op_code == OP_STATUS) ? 13'd1 : op_len;
      end
    end
  end

  // Next state and queue write strobes; hdr_q marks the instruction word as sent
  always_comb begin
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    tcnt_d     = tcnt_q;
    status_d   = status_q;
    instr_wr   = 1'b0;
    instr_word = 32'h0000_0000;
    dq_wr      = 1'b0;
    dq_byte    = 8'haa;
    wdat_ready = 1'b0;
    op_ready   = (state_q == S_IDLE);
    busy       = (state_q != S_IDLE);
    op_done    = (state_q == S_DONE);
    op_status  = status_q;

    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          hdr_d    = 1'b0;
          cnt_d    = '0;
          tcnt_d   = '0;
          status_d = len_bad ? 2'b10 : 2'b00;
          state_d  = len_bad ? S_DONE : S_CMD1;
        end
      end

      S_CMD1, S_CMD2: begin
        if (!hdr_q) begin
          instr_word = instr_fn(MODE_CMD, 12'd0);
          instr_wr   = !instr_full;
          if (!instr_full) hdr_d = 1'b1;
        end else begin
          dq_byte = (state_q == S_CMD1) ? cmd1_byte : cmd2_byte;
          dq_wr   = !dq_full;
          if (!dq_full) begin
            hdr_d = 1'b0;
            cnt_d = '0;
            if (state_q == S_CMD2)          state_d = S_DRAIN;
            else if (code_q == OP_STATUS)   state_d = S_RDATA;
            else                            state_d = S_ADDR;
          end
        end
      end

      S_ADDR: begin
        if (!hdr_q) begin
          instr_word = instr_fn(MODE_ADDR, 12'(addr_last));
          instr_wr   = !instr_full;
          if (!instr_full) hdr_d = 1'b1;
        end else begin
          dq_byte = addr_byte;
          dq_wr   = !dq_full;
          if (!dq_full) begin
            if (cnt_q == addr_last) begin
              hdr_d   = 1'b0;
              cnt_d   = '0;
              state_d = (code_q == OP_PROG) ? S_PAYLOAD : S_CMD2;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      S_PAYLOAD: begin
        if (!hdr_q) begin
          instr_word = instr_fn(MODE_DIN, 12'(len_q - 13'd1));
          instr_wr   = !instr_full;
          if (!instr_full) hdr_d = 1'b1;
        end else begin
          wdat_ready = !dq_full;
          if (wdat_valid && !dq_full) begin
            dq_wr   = 1'b1;
            dq_byte = wdat;
            if (cnt_q == len_q - 13'd1) begin
              hdr_d   = 1'b0;
              cnt_d   = '0;
              state_d = S_CMD2;
            end else begin
              cnt_d = cnt_q + CNT_W'(1);
            end
          end
        end
      end

      S_DRAIN: begin
        if (instr_empty) begin
          cnt_d   = '0;
          state_d = S_TWB;
        end
      end

      S_TWB: begin
        if (cnt_q == CNT_W'(TWB_CYC - 1)) begin
          tcnt_d  = '0;
          state_d = S_WAIT_RB;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // tWB has already elapsed, so a high flash_rdy here means the array is done
      S_WAIT_RB: begin
        if (flash_rdy) begin
          hdr_d   = 1'b0;
          state_d = (code_q == OP_READ) ? S_RDATA : S_DONE;
        end else if (tcnt_q == TIMEOUT_CYC - 24'd1) begin
          status_d[0] = 1'b1;
          state_d     = S_DONE;
        end else begin
          tcnt_d = tcnt_q + 24'd1;
        end
      end

      S_RDATA: begin
        if (!hdr_q && len_q >= 13'd2) begin
          instr_word = instr_fn(MODE_DOUT, 12'(len_q - 13'd2));
          instr_wr   = !instr_full;
          if (!instr_full) hdr_d = 1'b1;
        end else begin
          instr_word = instr_fn(MODE_DOUT_END, 12'd0);
          instr_wr   = !instr_full;
          if (!instr_full) begin
            hdr_d   = 1'b0;
            state_d = S_DONE;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_flash_op_sequencer.sv
// Scoreboard bench for flash_op_sequencer: a reference model queues the expected
// instruction words, FIFO bytes and completions; a negedge monitor pops and compares.
module tb_flash_op_sequencer;

  localparam logic [23:0] TMO = 24'd300;
  localparam logic [7:0] CMD1_B [4] = '{8'h00, 8'h80, 8'h60, 8'h70};
  localparam logic [7:0] CMD2_B [4] = '{8'h30, 8'h10, 8'hd0, 8'h00};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [1:0]  op_code = '0;
  logic [15:0] op_col = '0;
  logic [23:0] op_row = '0;
  logic [12:0] op_len = '0;
  logic        wdat_valid = 1'b0;
  logic [7:0]  wdat = '0;
  logic        wdat_ready;
  logic        instr_wr;
  logic [31:0] instr_word;
  logic        instr_full = 1'b0;
  logic        instr_empty = 1'b1;
  logic        dq_wr;
  logic [7:0]  dq_byte;
  logic        dq_full = 1'b0;
  logic        flash_rdy = 1'b1;
  logic        busy;
  logic        op_done;
  logic [1:0]  op_status;

  flash_op_sequencer #(
    .ADDR_COL_CYC(2), .ADDR_ROW_CYC(3), .TWB_CYC(8), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_col(op_col), .op_row(op_row), .op_len(op_len),
    .wdat_valid(wdat_valid), .wdat(wdat), .wdat_ready(wdat_ready),
    .instr_wr(instr_wr), .instr_word(instr_word), .instr_full(instr_full),
    .instr_empty(instr_empty), .dq_wr(dq_wr), .dq_byte(dq_byte), .dq_full(dq_full),
    .flash_rdy(flash_rdy), .busy(busy), .op_done(op_done), .op_status(op_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] exp_instr[$];
  logic [7:0]  exp_dq[$];
  logic [2:0]  exp_done[$];
  logic [7:0]  cur_pay[$];
  logic [7:0]  pay_q[$];

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int done_seen = 0;
  int done_cyc = 0;
  int acc_cyc = 0;
  int rdy_timer = 0;
  int ifull_pct = 0;
  int dfull_pct = 0;
  int empty_pct = 100;
  int wv_pct = 100;
  bit force_ifull = 1'b0;
  logic [1:0] last_status = 2'b00;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: outputs are stable at negedge and get captured at the next posedge
  always @(negedge clk) begin
    if (rst) begin
      if (instr_wr) begin
        check("instr_wr_while_full", 32'(instr_full), 32'd0);
        if (exp_instr.size() == 0) begin
          checks++; errors++;
          $display("FAIL instr_extra: got word 0x%0h, required no write", instr_word);
        end else check("instr_word", instr_word, exp_instr.pop_front());
      end
      if (dq_wr) begin
        check("dq_wr_while_full", 32'(dq_full), 32'd0);
        if (exp_dq.size() == 0) begin
          checks++; errors++;
          $display("FAIL dq_extra: got byte 0x%0h, required no write", dq_byte);
        end else check("dq_byte", 32'(dq_byte), 32'(exp_dq.pop_front()));
      end
      if (op_done) begin
        done_cnt++;
        done_cyc = cyc;
        if (exp_done.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_extra: got op_done status %0b, required none", op_status);
        end else begin
          logic [2:0] e;
          e = exp_done.pop_front();
          check("op_status", 32'(op_status), 32'(e[1:0]));
          if (e[2]) check("rdy_at_done", 32'(flash_rdy), 32'd1);
        end
        check("instr_left", 32'(exp_instr.size()), 32'd0);
        check("dq_left", 32'(exp_dq.size()), 32'd0);
        check("ready_in_done", 32'(op_ready), 32'd0);
      end
    end
  end

  // Queue-full / empty / R-B# stimulus
  initial forever begin
    @(posedge clk); #2;
    instr_full  = force_ifull || ($urandom_range(0, 99) < ifull_pct);
    dq_full     = ($urandom_range(0, 99) < dfull_pct);
    instr_empty = ($urandom_range(0, 99) < empty_pct);
    if (rdy_timer > 0) begin
      rdy_timer--;
      if (rdy_timer == 0) flash_rdy = 1'b1;
    end
  end

  // Program payload source with random valid gaps
  initial begin
    bit took;
    forever begin
      @(negedge clk);
      took = wdat_valid && wdat_ready;
      @(posedge clk); #2;
      if (took && pay_q.size() > 0) pay_q.delete(0);
      if (pay_q.size() > 0 && $urandom_range(0, 99) < wv_pct) begin
        wdat_valid = 1'b1;
        wdat = pay_q[0];
      end else begin
        wdat_valid = 1'b0;
        wdat = 8'($urandom);
      end
    end
  end

  // Reference model: expected words/bytes straight from the operation definitions
  task automatic model(input logic [1:0] code, input logic [15:0] col, input logic [23:0] row,
                       input logic [12:0] len, input bit tmo);
    int n;
    if (code <= 2'd1 && (len == 0 || len > 4096)) begin
      exp_done.push_back(3'b010);
      last_status = 2'b10;
      return;
    end
    exp_instr.push_back(32'h002);
    exp_dq.push_back(CMD1_B[code]);
    if (code != 2'd3) begin
      n = (code == 2'd2) ? 3 : 5;
      exp_instr.push_back(32'(((n - 1) << 8) | 3));
      if (code != 2'd2) begin
        exp_dq.push_back(col[7:0]);
        exp_dq.push_back(col[15:8]);
      end
      for (int i = 0; i < 3; i++) exp_dq.push_back(row[8*i +: 8]);
      if (code == 2'd1) begin
        exp_instr.push_back(32'(((int'(len) - 1) << 8) | 4));
        foreach (cur_pay[i]) begin
          exp_dq.push_back(cur_pay[i]);
          pay_q.push_back(cur_pay[i]);
        end
      end
      exp_instr.push_back(32'h002);
      exp_dq.push_back(CMD2_B[code]);
    end
    if (!tmo && (code == 2'd0 || code == 2'd3)) begin
      n = (code == 2'd3) ? 1 : int'(len);
      if (n >= 2) exp_instr.push_back(32'(((n - 2) << 8) | 5));
      exp_instr.push_back(32'h006);
    end
    last_status = tmo ? 2'b01 : 2'b00;
    exp_done.push_back({(code != 2'd3) && !tmo, last_status});
  endtask

  // rdy_delay: 0 = R/B# already high, >0 = rises that many cycles after accept, <0 = stays low
  task automatic start_op(input logic [1:0] code, input logic [15:0] col, input logic [23:0] row,
                          input logic [12:0] len, input int rdy_delay);
    model(code, col, row, len, (rdy_delay < 0) && (code != 2'd3));
    @(posedge clk); #1;
    check("op_ready_idle", 32'(op_ready), 32'd1);
    done_seen = done_cnt;
    op_code = code; op_col = col; op_row = row; op_len = len;
    op_valid = 1'b1;
    flash_rdy = (rdy_delay == 0);
    rdy_timer = (rdy_delay > 0) ? rdy_delay : 0;
    @(posedge clk); #1;
    acc_cyc = cyc;
    op_valid = 1'b0;
  endtask

  task automatic finish_op(input int budget);
    int n = 0;
    while (done_cnt == done_seen && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (done_cnt == done_seen) begin
      checks++; errors++;
      $display("FAIL done_timeout: no op_done within %0d cycles", budget);
      return;
    end
    @(posedge clk); #1;
    check("status_hold", 32'(op_status), 32'(last_status));
    check("ready_after_done", 32'(op_ready), 32'd1);
  endtask

  task automatic wait_dq_level(input int level, input string name);
    int n = 0;
    while (exp_dq.size() > level && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, 32'(exp_dq.size() <= level), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_op_ready"}, 32'(op_ready), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_instr_wr"}, 32'(instr_wr), 32'd0);
    check({tag, "_instr_word"}, instr_word, 32'd0);
    check({tag, "_dq_wr"}, 32'(dq_wr), 32'd0);
    check({tag, "_dq_byte"}, 32'(dq_byte), 32'haa);
    check({tag, "_op_done"}, 32'(op_done), 32'd0);
    check({tag, "_op_status"}, 32'(op_status), 32'd0);
    check({tag, "_wdat_ready"}, 32'(wdat_ready), 32'd0);
  endtask

  initial begin
    int sz_i;
    int sz_d;
    #23;
    check_reset_outputs("reset");
    @(negedge clk); rst = 1'b1;

    // Page read from the worked example
    start_op(2'd0, 16'h0123, 24'h045678, 13'd4, 30);
    finish_op(2000);

    // Program with payload gaps; R/B# returns late
    cur_pay = '{8'haa, 8'hbb, 8'hcc};
    wv_pct = 40;
    start_op(2'd1, 16'h0010, 24'h000200, 13'd3, 40);
    finish_op(2000);
    cur_pay.delete();

    // Erase with R/B# stuck low -> timeout
    start_op(2'd2, 16'h0000, 24'h000100, 13'd0, -1);
    finish_op(int'(TMO) + 2000);

    // Status read: no busy wait even with R/B# low
    start_op(2'd3, 16'h0000, 24'h0, 13'd0, -1);
    finish_op(50);
    check("status_latency_le5", 32'((done_cyc - acc_cyc) <= 5), 32'd1);

    // Illegal lengths and the single-byte read
    start_op(2'd0, 16'h1, 24'h2, 13'd0, 0);
    finish_op(20);
    check("illegal0_latency", 32'(done_cyc - acc_cyc), 32'd0);
    start_op(2'd0, 16'h1, 24'h2, 13'd4097, 0);
    finish_op(20);
    check("illegal4097_latency", 32'(done_cyc - acc_cyc), 32'd0);
    start_op(2'd0, 16'habcd, 24'h123456, 13'd1, 0);
    finish_op(2000);
    start_op(2'd0, 16'habcd, 24'h123456, 13'd4096, 5);
    finish_op(2000);

    // instr_full held across the start of ADDR: nothing may be written
    start_op(2'd0, 16'h5a5a, 24'ha5a5a5, 13'd8, 10);
    wait_dq_level(6, "reached_addr");
    force_ifull = 1'b1;
    sz_i = exp_instr.size();
    sz_d = exp_dq.size();
    repeat (15) @(posedge clk);
    #1;
    check("ifull_stall_instr", 32'(exp_instr.size()), 32'(sz_i));
    check("ifull_stall_dq", 32'(exp_dq.size()), 32'(sz_d));
    force_ifull = 1'b0;
    dfull_pct = 50;
    finish_op(2000);
    dfull_pct = 0;

    // Randomized mix with toggling full/empty flags
    for (int k = 0; k < 25; k++) begin
      logic [1:0]  c;
      logic [12:0] l;
      c = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) l = ($urandom_range(0, 1) == 0) ? 13'd0 : 13'($urandom_range(4097, 8191));
      else l = 13'($urandom_range(1, 48));
      ifull_pct = $urandom_range(0, 40);
      dfull_pct = $urandom_range(0, 40);
      empty_pct = $urandom_range(50, 100);
      wv_pct    = $urandom_range(30, 100);
      cur_pay.delete();
      if (c == 2'd1 && l != 0 && l <= 13'd4096)
        for (int i = 0; i < int'(l); i++) cur_pay.push_back(8'($urandom));
      start_op(c, 16'($urandom), 24'($urandom), l, $urandom_range(0, 80));
      finish_op(4000);
    end
    ifull_pct = 0; dfull_pct = 0; empty_pct = 100; wv_pct = 60;

    // Reset in the middle of a program payload
    cur_pay.delete();
    for (int i = 0; i < 40; i++) cur_pay.push_back(8'(i * 7 + 3));
    start_op(2'd1, 16'h0f0f, 24'h00abcd, 13'd40, 50);
    wait_dq_level(30, "reached_payload");
    @(negedge clk); #2;
    rst = 1'b0;
    #1;
    check_reset_outputs("midop_reset");
    exp_instr.delete(); exp_dq.delete(); exp_done.delete(); pay_q.delete();
    rdy_timer = 0; flash_rdy = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(op_ready), 32'd1);
    check("busy_after_reset", 32'(busy), 32'd0);

    // Normal operation after reset
    start_op(2'd3, 16'h0, 24'h0, 13'd0, 0);
    finish_op(50);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
